// File: rtl/mfcc_sched_pkg.sv
// Shared types and default constants for the MFCC frame scheduler.
package mfcc_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_WIN = 3'd1,
        S_HAMMING  = 3'd2,
        S_FFT      = 3'd3,
        S_MEL      = 3'd4,
        S_DCT      = 3'd5
    } sched_state_t;

    localparam int FRAME_CNT_WIDTH_DEF = 16;
    localparam int TIMEOUT_CYCLES_DEF  = 65535;

endpackage

// File: rtl/sched_watchdog.sv
// Per-stage watchdog: counts cycles spent in one processing state and flags a timeout.
// Only instantiated when SCHED_WATCHDOG_EN is defined.
module sched_watchdog
    import mfcc_sched_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  sched_state_t state_i,
    output logic         timeout_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    sched_state_t  prev_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          in_stage;
    logic          same_state;

    assign in_stage   = state_i inside {S_HAMMING, S_FFT, S_MEL, S_DCT};
    assign same_state = (state_i == prev_q);

    always_comb begin
        cnt_d = cnt_q;
        if (!same_state) begin
            cnt_d = '0;
        end else if (in_stage && cnt_q != CW'(TIMEOUT_CYCLES)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= S_IDLE;
            cnt_q  <= '0;
        end else begin
            prev_q <= state_i;
            cnt_q  <= cnt_d;
        end
    end

    assign timeout_o = in_stage && same_state && (cnt_q == CW'(TIMEOUT_CYCLES));

endmodule

// File: rtl/mfcc_frame_scheduler.sv
// Central sequencer for window -> Hamming -> FFT -> MEL -> DCT, with early window advance.
// Optional per-stage watchdog enabled by defining SCHED_WATCHDOG_EN.
module mfcc_frame_scheduler
    import mfcc_sched_pkg::*;
#(
    parameter int FRAME_CNT_WIDTH = FRAME_CNT_WIDTH_DEF,
    parameter int TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable_i,
    input  logic                       abort_i,
    input  logic [FRAME_CNT_WIDTH-1:0] num_frames_i,
    input  logic                       window_ready_i,
    input  logic                       window_idle_i,
    input  logic                       hamming_done_i,
    input  logic                       fft_done_i,
    input  logic                       mel_done_i,
    input  logic                       dct_done_i,
    output logic                       hamming_start_o,
    output logic                       fft_start_o,
    output logic                       mel_start_o,
    output logic                       dct_start_o,
    output logic                       start_move_o,
    output logic                       frame_done_o,
    output logic [FRAME_CNT_WIDTH-1:0] frame_count_o,
    output logic                       busy_o,
    output logic [2:0]                 stage_o,
    output logic                       overrun_o,
    output logic                       error_o
);

    // Handshake: *_done_i and window_ready_i are one-cycle pulses sampled on posedge;
    // every *_start_o, start_move_o and frame_done_o is a registered one-cycle pulse
    // raised in the cycle after the condition that triggers it.

    sched_state_t               state_q, state_d, stage_q;
    logic                       pending_q, pending_d;
    logic                       move_req_q, move_req_d;
    logic                       overrun_q, overrun_d;
    logic                       error_q, error_d;
    logic [FRAME_CNT_WIDTH-1:0] count_q, count_d, count_inc;
    logic [FRAME_CNT_WIDTH-1:0] num_q, num_d;
    logic                       ham_d, fft_d, mel_d, dct_d, move_d, fdone_d;
    logic                       ham_q, fft_q, mel_q, dct_q, move_q, fdone_q;
    logic                       busy_q;
    logic                       wdog_timeout;

`ifdef SCHED_WATCHDOG_EN
    sched_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .state_i   (state_q),
        .timeout_o (wdog_timeout)
    );
`else
    // Watchdog compiled out: the limit is never reached.
    assign wdog_timeout = (TIMEOUT_CYCLES < 0);
`endif

    assign count_inc = (count_q == '1) ? count_q : count_q + FRAME_CNT_WIDTH'(1);

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        move_req_d = move_req_q;
        overrun_d  = overrun_q;
        error_d    = error_q;
        count_d    = count_q;
        num_d      = num_q;
        ham_d      = 1'b0;
        fft_d      = 1'b0;
        mel_d      = 1'b0;
        dct_d      = 1'b0;
        move_d     = 1'b0;
        fdone_d    = 1'b0;

        if (move_req_q && window_idle_i) begin
            move_d     = 1'b1;
            move_req_d = 1'b0;
        end

        if (window_ready_i && state_q != S_WAIT_WIN) begin
            if (pending_q) overrun_d = 1'b1;
            else           pending_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (enable_i) begin
                    state_d   = S_WAIT_WIN;
                    num_d     = num_frames_i;
                    count_d   = '0;
                    overrun_d = 1'b0;
                    error_d   = 1'b0;
                end
            end
            S_WAIT_WIN: begin
                if (window_ready_i || pending_q) begin
                    ham_d     = 1'b1;
                    pending_d = 1'b0;
                    state_d   = S_HAMMING;
                end
            end
            S_HAMMING: begin
                if (hamming_done_i) begin
                    fft_d      = 1'b1;
                    move_req_d = 1'b1;
                    state_d    = S_FFT;
                end
            end
            S_FFT: begin
                if (fft_done_i) begin
                    mel_d   = 1'b1;
                    state_d = S_MEL;
                end
            end
            S_MEL: begin
                if (mel_done_i) begin
                    dct_d   = 1'b1;
                    state_d = S_DCT;
                end
            end
            S_DCT: begin
                if (dct_done_i) begin
                    fdone_d = 1'b1;
                    count_d = count_inc;
                    if ((num_q != '0 && count_inc == num_q) || !enable_i) begin
                        state_d   = S_IDLE;
                        pending_d = 1'b0;
                    end else begin
                        state_d = S_WAIT_WIN;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort and watchdog timeout override everything above; the frame count survives.
        if (abort_i || wdog_timeout) begin
            state_d    = S_IDLE;
            pending_d  = 1'b0;
            move_req_d = 1'b0;
            overrun_d  = overrun_q;
            error_d    = error_q | wdog_timeout;
            count_d    = count_q;
            num_d      = num_q;
            ham_d      = 1'b0;
            fft_d      = 1'b0;
            mel_d      = 1'b0;
            dct_d      = 1'b0;
            move_d     = 1'b0;
            fdone_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            stage_q    <= S_IDLE;
            pending_q  <= 1'b0;
            move_req_q <= 1'b0;
            overrun_q  <= 1'b0;
            error_q    <= 1'b0;
            count_q    <= '0;
            num_q      <= '0;
            ham_q      <= 1'b0;
            fft_q      <= 1'b0;
            mel_q      <= 1'b0;
            dct_q      <= 1'b0;
            move_q     <= 1'b0;
            fdone_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            // A timed-out stage stays visible for one extra cycle.
            stage_q    <= wdog_timeout ? state_q : state_d;
            pending_q  <= pending_d;
            move_req_q <= move_req_d;
            overrun_q  <= overrun_d;
            error_q    <= error_d;
            count_q    <= count_d;
            num_q      <= num_d;
            ham_q      <= ham_d;
            fft_q      <= fft_d;
            mel_q      <= mel_d;
            dct_q      <= dct_d;
            move_q     <= move_d;
            fdone_q    <= fdone_d;
            busy_q     <= (state_d != S_IDLE);
        end
    end

    assign hamming_start_o = ham_q;
    assign fft_start_o     = fft_q;
    assign mel_start_o     = mel_q;
    assign dct_start_o     = dct_q;
    assign start_move_o    = move_q;
    assign frame_done_o    = fdone_q;
    assign frame_count_o   = count_q;
    assign busy_o          = busy_q;
    assign stage_o         = stage_q;
    assign overrun_o       = overrun_q;
    assign error_o         = error_q;

endmodule

// File: tb/tb_mfcc_frame_scheduler.sv
// Directed bench for mfcc_frame_scheduler: expected pulse events go into a queue,
// a negedge monitor pops and compares them as the DUT emits pulses.
module tb_mfcc_frame_scheduler;

    localparam int W  = 16;
    localparam int EW = 23;

    localparam logic [3:0] EV_HAM   = 4'd0;
    localparam logic [3:0] EV_FFT   = 4'd1;
    localparam logic [3:0] EV_MEL   = 4'd2;
    localparam logic [3:0] EV_DCT   = 4'd3;
    localparam logic [3:0] EV_MOVE  = 4'd4;
    localparam logic [3:0] EV_FRAME = 4'd5;

    localparam int IN_READY = 0;
    localparam int IN_HDONE = 1;
    localparam int IN_FDONE = 2;
    localparam int IN_MDONE = 3;
    localparam int IN_DDONE = 4;
    localparam int IN_ABORT = 5;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         enable_i = 1'b0;
    logic         abort_i = 1'b0;
    logic [W-1:0] num_frames_i = '0;
    logic         window_ready_i = 1'b0;
    logic         window_idle_i = 1'b1;
    logic         hamming_done_i = 1'b0;
    logic         fft_done_i = 1'b0;
    logic         mel_done_i = 1'b0;
    logic         dct_done_i = 1'b0;
    logic         hamming_start_o, fft_start_o, mel_start_o, dct_start_o;
    logic         start_move_o, frame_done_o, busy_o, overrun_o, error_o;
    logic [W-1:0] frame_count_o;
    logic [2:0]   stage_o;

    logic [EW-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    mfcc_frame_scheduler #(
        .FRAME_CNT_WIDTH (W),
        .TIMEOUT_CYCLES  (20)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .enable_i        (enable_i),
        .abort_i         (abort_i),
        .num_frames_i    (num_frames_i),
        .window_ready_i  (window_ready_i),
        .window_idle_i   (window_idle_i),
        .hamming_done_i  (hamming_done_i),
        .fft_done_i      (fft_done_i),
        .mel_done_i      (mel_done_i),
        .dct_done_i      (dct_done_i),
        .hamming_start_o (hamming_start_o),
        .fft_start_o     (fft_start_o),
        .mel_start_o     (mel_start_o),
        .dct_start_o     (dct_start_o),
        .start_move_o    (start_move_o),
        .frame_done_o    (frame_done_o),
        .frame_count_o   (frame_count_o),
        .busy_o          (busy_o),
        .stage_o         (stage_o),
        .overrun_o       (overrun_o),
        .error_o         (error_o)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    function automatic logic out_bit(input int sel);
        case (sel)
            0:       return hamming_start_o;
            1:       return fft_start_o;
            2:       return mel_start_o;
            3:       return dct_start_o;
            4:       return start_move_o;
            default: return frame_done_o;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] code, input logic [W-1:0] cnt, input logic [2:0] stg);
        exp_q.push_back({code, cnt, stg});
    endtask

    task automatic set_in(input int sel, input logic v);
        case (sel)
            IN_READY: window_ready_i = v;
            IN_HDONE: hamming_done_i = v;
            IN_FDONE: fft_done_i     = v;
            IN_MDONE: mel_done_i     = v;
            IN_DDONE: dct_done_i     = v;
            default:  abort_i        = v;
        endcase
    endtask

    task automatic pulse(input int sel);
        set_in(sel, 1'b1);
        @(negedge clk);
        set_in(sel, 1'b0);
    endtask

    task automatic gap();
        repeat (4) @(negedge clk);
    endtask

    // One full frame with window_idle_i high: move follows fft_start by one cycle.
    task automatic do_frame(input logic [W-1:0] cnt, input logic [2:0] end_stage);
        push(EV_HAM, cnt, 3'd2);
        pulse(IN_READY);
        gap();
        push(EV_FFT, cnt, 3'd3);
        push(EV_MOVE, cnt, 3'd3);
        pulse(IN_HDONE);
        gap();
        push(EV_MEL, cnt, 3'd4);
        pulse(IN_FDONE);
        gap();
        push(EV_DCT, cnt, 3'd5);
        pulse(IN_MDONE);
        gap();
        push(EV_FRAME, cnt + W'(1), end_stage);
        pulse(IN_DDONE);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 6; k++) begin
                if (out_bit(k)) begin
                    logic [EW-1:0] act;
                    logic [EW-1:0] exp;
                    act = {4'(k), frame_count_o, stage_o};
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_pulse: got event %0h, expected none", act);
                    end else begin
                        exp = exp_q.pop_front();
                        if (act !== exp) begin
                            n_err++;
                            $display("FAIL event: got %0h, expected %0h", act, exp);
                        end
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int early_moves;

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_pulses", {26'd0, hamming_start_o, fft_start_o, mel_start_o,
                             dct_start_o, start_move_o, frame_done_o}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_stage", 32'(stage_o), 32'd0);
        check("rst_count", 32'(frame_count_o), 32'd0);
        check("rst_overrun", 32'(overrun_o), 32'd0);
        check("rst_error", 32'(error_o), 32'd0);

        // 1: two programmed frames
        num_frames_i = W'(2);
        enable_i = 1'b1;
        @(negedge clk);
        check("t1_wait_stage", 32'(stage_o), 32'd1);
        check("t1_busy", 32'(busy_o), 32'd1);
        do_frame(W'(0), 3'd1);
        do_frame(W'(1), 3'd0);
        enable_i = 1'b0;
        @(negedge clk);
        check("t1_count", 32'(frame_count_o), 32'd2);
        check("t1_idle_busy", 32'(busy_o), 32'd0);
        check("t1_idle_stage", 32'(stage_o), 32'd0);

        // 2: window buffer busy delays start_move
        num_frames_i = W'(1);
        enable_i = 1'b1;
        @(negedge clk);
        window_idle_i = 1'b0;
        push(EV_HAM, W'(0), 3'd2);
        pulse(IN_READY);
        gap();
        push(EV_FFT, W'(0), 3'd3);
        pulse(IN_HDONE);
        early_moves = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (start_move_o) early_moves++;
        end
        check("t2_no_early_move", 32'(early_moves), 32'd0);
        window_idle_i = 1'b1;
        push(EV_MOVE, W'(0), 3'd3);
        @(negedge clk);
        check("t2_move_now", 32'(start_move_o), 32'd1);
        @(negedge clk);
        check("t2_move_once", 32'(start_move_o), 32'd0);
        push(EV_MEL, W'(0), 3'd4);
        pulse(IN_FDONE);
        gap();
        push(EV_DCT, W'(0), 3'd5);
        pulse(IN_MDONE);
        gap();
        push(EV_FRAME, W'(1), 3'd0);
        pulse(IN_DDONE);
        enable_i = 1'b0;
        @(negedge clk);
        check("t2_count", 32'(frame_count_o), 32'd1);

        // 3: early window_ready becomes pending, a second one overruns
        num_frames_i = W'(2);
        enable_i = 1'b1;
        @(negedge clk);
        check("t3_overrun_cleared", 32'(overrun_o), 32'd0);
        push(EV_HAM, W'(0), 3'd2);
        pulse(IN_READY);
        gap();
        push(EV_FFT, W'(0), 3'd3);
        push(EV_MOVE, W'(0), 3'd3);
        pulse(IN_HDONE);
        gap();
        push(EV_MEL, W'(0), 3'd4);
        pulse(IN_FDONE);
        pulse(IN_READY);
        check("t3_pending_no_overrun", 32'(overrun_o), 32'd0);
        @(negedge clk);
        push(EV_DCT, W'(0), 3'd5);
        pulse(IN_MDONE);
        pulse(IN_READY);
        check("t3_overrun", 32'(overrun_o), 32'd1);
        push(EV_FRAME, W'(1), 3'd1);
        push(EV_HAM, W'(1), 3'd2);
        pulse(IN_DDONE);
        @(negedge clk);
        check("t3_pending_start", 32'(hamming_start_o), 32'd1);
        gap();
        push(EV_FFT, W'(1), 3'd3);
        push(EV_MOVE, W'(1), 3'd3);
        pulse(IN_HDONE);
        gap();
        push(EV_MEL, W'(1), 3'd4);
        pulse(IN_FDONE);
        gap();
        push(EV_DCT, W'(1), 3'd5);
        pulse(IN_MDONE);
        gap();
        push(EV_FRAME, W'(2), 3'd0);
        pulse(IN_DDONE);
        enable_i = 1'b0;
        @(negedge clk);
        check("t3_overrun_sticky", 32'(overrun_o), 32'd1);

        // 4: abort in S_FFT after three frames
        num_frames_i = W'(0);
        enable_i = 1'b1;
        @(negedge clk);
        do_frame(W'(0), 3'd1);
        do_frame(W'(1), 3'd1);
        do_frame(W'(2), 3'd1);
        window_idle_i = 1'b0;
        push(EV_HAM, W'(3), 3'd2);
        pulse(IN_READY);
        gap();
        push(EV_FFT, W'(3), 3'd3);
        pulse(IN_HDONE);
        gap();
        enable_i = 1'b0;
        pulse(IN_ABORT);
        check("t4_abort_stage", 32'(stage_o), 32'd0);
        check("t4_abort_busy", 32'(busy_o), 32'd0);
        check("t4_abort_count", 32'(frame_count_o), 32'd3);
        window_idle_i = 1'b1;
        pulse(IN_FDONE);
        repeat (10) @(negedge clk);
        check("t4_still_idle", 32'(stage_o), 32'd0);
        check("t4_count_kept", 32'(frame_count_o), 32'd3);

        // 5: continuous mode, enable dropped in S_MEL
        num_frames_i = W'(0);
        enable_i = 1'b1;
        @(negedge clk);
        pulse(IN_DDONE);
        check("t5_stray_done", 32'(stage_o), 32'd1);
        push(EV_HAM, W'(0), 3'd2);
        pulse(IN_READY);
        gap();
        push(EV_FFT, W'(0), 3'd3);
        push(EV_MOVE, W'(0), 3'd3);
        pulse(IN_HDONE);
        gap();
        push(EV_MEL, W'(0), 3'd4);
        pulse(IN_FDONE);
        enable_i = 1'b0;
        gap();
        push(EV_DCT, W'(0), 3'd5);
        pulse(IN_MDONE);
        gap();
        push(EV_FRAME, W'(1), 3'd0);
        pulse(IN_DDONE);
        @(negedge clk);
        check("t5_idle_stage", 32'(stage_o), 32'd0);
        check("t5_count", 32'(frame_count_o), 32'd1);

        // 6: mel_done never arrives
        num_frames_i = W'(1);
        enable_i = 1'b1;
        @(negedge clk);
        push(EV_HAM, W'(0), 3'd2);
        pulse(IN_READY);
        gap();
        push(EV_FFT, W'(0), 3'd3);
        push(EV_MOVE, W'(0), 3'd3);
        pulse(IN_HDONE);
        gap();
        push(EV_MEL, W'(0), 3'd4);
        pulse(IN_FDONE);
        repeat (40) @(negedge clk);
`ifdef SCHED_WATCHDOG_EN
        check("t6_error", 32'(error_o), 32'd1);
`else
        check("t6_stuck_stage", 32'(stage_o), 32'd4);
        check("t6_no_error", 32'(error_o), 32'd0);
`endif

        // mid-frame reset
        enable_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_stage", 32'(stage_o), 32'd0);
        check("rst_mid_busy", 32'(busy_o), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Safety net against a stuck run.
    initial begin
        #200000;
        $display("FAIL time_limit: got no finish, expected finish before 200000");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1);
    end

endmodule
